// File: rtl/conv_out_collector_pkg.sv
// Shared definitions for the convolution output collector: state encoding and
// the output-depth helper.
package conv_out_collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   function automatic int unsigned out_depth(input int unsigned img_w,
                                             input int unsigned img_h);
      return (img_w - 2) * (img_h - 2);
   endfunction

endpackage

// File: rtl/conv_out_collector_out_ram.sv
// Output RAM: one write port, registered read-before-write read port that
// returns zero for out-of-range addresses.
module out_ram #(
   parameter int n = 8,
   parameter int A = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [A-1:0] wa,
   input  logic [n-1:0] wd,
   input  logic         re,
   input  logic [A-1:0] ra,
   input  logic         ra_ok,
   output logic [n-1:0] rd
);

   logic [n-1:0] mem [2**A];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rd <= '0;
      else if (re) rd <= ra_ok ? mem[ra] : '0;
   end

endmodule

// File: rtl/conv_out_collector.sv
// Collects raster-ordered convolution results, drops the two wrap-around
// positions per line, optionally applies ReLU and stores them for host readback.
module conv_out_collector
   import conv_out_collector_pkg::*;
#(
   parameter int n     = 8,
   parameter int IMG_W = 6,
   parameter int IMG_H = 6,
   parameter int RELU  = 0,
   parameter int A     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         in_valid,
   input  logic [n-1:0] in_data,
   input  logic         out_rd,
   input  logic [A-1:0] out_adr,
   output logic [n-1:0] out_data,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic [A:0]   wr_count
);

   localparam int unsigned OUT_DEPTH = out_depth(IMG_W, IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H + 1);

   localparam logic [CW-1:0] COL_KEEP = CW'(IMG_W - 2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_KEEP = RW'(IMG_H - 2);
   localparam logic [A-1:0]  PTR_LAST = A'(OUT_DEPTH - 1);
   localparam logic [A:0]    CNT_LAST = (A+1)'(OUT_DEPTH - 1);
   localparam logic [A:0]    CNT_DEPTH = (A+1)'(OUT_DEPTH);

   state_t        state, state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [A-1:0]  wr_ptr;
   logic          beat, keep, we;
   logic [n-1:0]  wd;
   logic          ra_ok;

   assign beat  = in_valid && !start && (state == COLLECT);
   // row guard never trips before DONE; it only bounds the frame explicitly
   assign keep  = (col < COL_KEEP) && (row < ROW_KEEP);
   assign we    = beat && keep;
   assign wd    = ((RELU != 0) && in_data[n-1]) ? '0 : in_data;
   assign ra_ok = {1'b0, out_adr} < CNT_DEPTH;

   assign busy = (state == COLLECT);
   assign done = (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = COLLECT;
         COLLECT: begin
            if (start)                            state_nx = COLLECT;
            else if (we && (wr_count == CNT_LAST)) state_nx = DONE;
         end
         DONE:    if (start) state_nx = COLLECT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         wr_ptr   <= '0;
         wr_count <= '0;
         ovf      <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            col      <= '0;
            row      <= '0;
            wr_ptr   <= '0;
            wr_count <= '0;
            ovf      <= 1'b0;
         end else if (in_valid) begin
            if (state == COLLECT) begin
               if (col == COL_LAST) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
               if (keep) begin
                  if (wr_ptr != PTR_LAST) wr_ptr <= wr_ptr + 1'b1;
                  wr_count <= wr_count + 1'b1;
               end
            end else begin
               ovf <= 1'b1;
            end
         end
      end
   end

   out_ram #(.n(n), .A(A)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .wa    (wr_ptr),
      .wd    (wd),
      .re    (out_rd),
      .ra    (out_adr),
      .ra_ok (ra_ok),
      .rd    (out_data)
   );

endmodule
